// File: rtl/ref_decoder_if.sv
// ============================================================================
// Module      : ref_decoder_if
// Description : Handshake and table-port bundle for the reference decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ref_decoder_if #(
  parameter int CANT_BITS = 16
);
  logic                        En;
  logic                        Start;
  logic signed [CANT_BITS-1:0] Dato_in;
  logic signed [CANT_BITS-1:0] Const_in;
  logic [3:0]                  Estado_idx;
  logic [3:0]                  Estado_out;
  logic signed [CANT_BITS:0]   Error_out;
  logic                        Busy;
  logic                        Done;

  modport master (
    output En, Start, Dato_in, Const_in,
    input  Estado_idx, Estado_out, Error_out, Busy, Done
  );

  modport slave (
    input  En, Start, Dato_in, Const_in,
    output Estado_idx, Estado_out, Error_out, Busy, Done
  );
endinterface

`default_nettype wire

// File: rtl/ref_decoder.sv
// ============================================================================
// Module      : ref_decoder
// Description : Scans the 16-entry constant table and reports the index of the
//               constant nearest the latched value, plus the signed residual.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ref_decoder #(
  parameter int CANT_BITS = 16
) (
  input  wire logic      CLK_G,
  input  wire logic      reset_G,
  ref_decoder_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_LAST_IDX = 4'd15;

  state_t                      r_state,     w_nxt_state;
  logic signed [CANT_BITS-1:0] r_d,         w_nxt_d;
  logic [3:0]                  r_idx,       w_nxt_idx;
  logic [3:0]                  r_best_idx,  w_nxt_best_idx;
  logic [CANT_BITS:0]          r_best_dist, w_nxt_best_dist;
  logic signed [CANT_BITS:0]   r_best_diff, w_nxt_best_diff;
  logic [3:0]                  r_est_out,   w_nxt_est_out;
  logic signed [CANT_BITS:0]   r_err_out,   w_nxt_err_out;
  logic                        r_busy,      w_nxt_busy;
  logic                        r_done,      w_nxt_done;

  logic signed [CANT_BITS:0]   w_diff;
  logic [CANT_BITS:0]          w_dist;

  // One extra bit makes the subtraction and its magnitude overflow-free.
  assign w_diff = {r_d[CANT_BITS-1], r_d} - {bus.Const_in[CANT_BITS-1], bus.Const_in};
  assign w_dist = w_diff[CANT_BITS] ? (-w_diff) : w_diff;

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_d         = r_d;
    w_nxt_idx       = r_idx;
    w_nxt_best_idx  = r_best_idx;
    w_nxt_best_dist = r_best_dist;
    w_nxt_best_diff = r_best_diff;
    w_nxt_est_out   = r_est_out;
    w_nxt_err_out   = r_err_out;
    w_nxt_busy      = r_busy;
    w_nxt_done      = r_done;
    case (r_state)
      S_IDLE: begin
        w_nxt_done = 1'b0;
        w_nxt_busy = 1'b0;
        if (bus.Start) begin
          w_nxt_d     = bus.Dato_in;
          w_nxt_idx   = 4'd0;
          w_nxt_busy  = 1'b1;
          w_nxt_state = S_SCAN;
        end
      end
      S_SCAN: begin
        // Strict compare keeps the lower index on a tie.
        if ((r_idx == 4'd0) || (w_dist < r_best_dist)) begin
          w_nxt_best_idx  = r_idx;
          w_nxt_best_dist = w_dist;
          w_nxt_best_diff = w_diff;
        end
        if (r_idx == c_LAST_IDX) begin
          w_nxt_idx   = 4'd0;
          w_nxt_state = S_DONE;
        end else begin
          w_nxt_idx = r_idx + 4'd1;
        end
      end
      S_DONE: begin
        w_nxt_est_out = r_best_idx;
        w_nxt_err_out = r_best_diff;
        w_nxt_done    = 1'b1;
        w_nxt_state   = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_G) begin
    if (reset_G) begin
      r_state     <= S_IDLE;
      r_d         <= '0;
      r_idx       <= '0;
      r_best_idx  <= '0;
      r_best_dist <= '0;
      r_best_diff <= '0;
      r_est_out   <= '0;
      r_err_out   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (bus.En) begin
      r_state     <= w_nxt_state;
      r_d         <= w_nxt_d;
      r_idx       <= w_nxt_idx;
      r_best_idx  <= w_nxt_best_idx;
      r_best_dist <= w_nxt_best_dist;
      r_best_diff <= w_nxt_best_diff;
      r_est_out   <= w_nxt_est_out;
      r_err_out   <= w_nxt_err_out;
      r_busy      <= w_nxt_busy;
      r_done      <= w_nxt_done;
    end
  end

  assign bus.Estado_idx = r_idx;
  assign bus.Estado_out = r_est_out;
  assign bus.Error_out  = r_err_out;
  assign bus.Busy       = r_busy;
  assign bus.Done       = r_done;

endmodule

`default_nettype wire
